// File: rtl/paddle_ctrl.sv
// Pong paddle controller: synchronises and debounces two raw buttons, then steps
// the paddle one row per press, with auto-repeat after a hold delay.
module paddle_ctrl #(
    parameter int DEBOUNCE = 1000,
    parameter int HOLD     = 5000,
    parameter int REPEAT   = 1000,
    parameter int HEIGHT   = 3,
    parameter int INIT_Y   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       en,
    output logic [3:0] y,
    output logic       step
);

    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam int TMAX = (HOLD > REPEAT) ? HOLD : REPEAT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE - 1);
    localparam logic [TW-1:0]  HOLD_LAST = TW'(HOLD - 1);
    localparam logic [TW-1:0]  RPT_LAST  = TW'(REPEAT - 1);
    localparam logic [3:0]     Y_MAX     = 4'(16 - HEIGHT);
    localparam logic [3:0]     Y_INIT    = 4'(INIT_Y);

    typedef enum logic [1:0] {REQ_NONE, REQ_UP, REQ_DOWN} req_e;
    typedef enum logic [1:0] {IDLE, FIRST, RPT} state_e;

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]     sync1_q, sync2_q, db_q;
    logic [DBW-1:0] dbCnt_q [2];

    state_e         state_q, state_d;
    req_e           dir_q, dir_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [3:0]     y_q, y_d;
    logic           step_q, step_d;

    req_e           req;
    req_e           stepDir;
    logic           doStep;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= {btn_down, btn_up};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    dbCnt_q[i] <= '0;
                end else if (dbCnt_q[i] == DB_LAST) begin
                    db_q[i]    <= sync2_q[i];
                    dbCnt_q[i] <= '0;
                end else begin
                    dbCnt_q[i] <= dbCnt_q[i] + DBW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            dir_q   <= REQ_UP;
            timer_q <= '0;
            y_q     <= Y_INIT;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            timer_q <= timer_d;
            y_q     <= y_d;
            step_q  <= step_d;
        end
    end

    // Pressing both buttons cancels out rather than favouring either direction.
    always_comb begin
        req = REQ_NONE;
        if (db_q[0] && !db_q[1]) begin
            req = REQ_UP;
        end else if (db_q[1] && !db_q[0]) begin
            req = REQ_DOWN;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        doStep  = 1'b0;
        stepDir = dir_q;
        y_d     = y_q;
        step_d  = 1'b0;

        if (!en) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != REQ_NONE) begin
                        doStep  = 1'b1;
                        stepDir = req;
                        dir_d   = req;
                        timer_d = '0;
                        state_d = FIRST;
                    end
                end
                FIRST, RPT: begin
                    if (req == REQ_NONE) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (req != dir_q) begin
                        doStep  = 1'b1;
                        stepDir = req;
                        dir_d   = req;
                        timer_d = '0;
                    end else if (timer_q == ((state_q == FIRST) ? HOLD_LAST : RPT_LAST)) begin
                        doStep  = 1'b1;
                        timer_d = '0;
                        state_d = RPT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end

        // At the screen edge the step is swallowed but the repeat timing carries on.
        if (doStep) begin
            if (stepDir == REQ_UP && y_q != 4'd0) begin
                y_d    = y_q - 4'd1;
                step_d = 1'b1;
            end else if (stepDir == REQ_DOWN && y_q < Y_MAX) begin
                y_d    = y_q + 4'd1;
                step_d = 1'b1;
            end
        end
    end

    assign y    = y_q;
    assign step = step_q;

endmodule
